// File: rtl/operand_read_stage_if.sv
// operand_read_stage_if: decode/regfile/forwarding/execute signals of the operand-read stage
interface operand_read_stage_if #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 16,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int CTRL_W  = 16
);
  localparam int REG_W = $clog2(REG_CNT);
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_SRC-1:0]        in_rd_en;
  logic [NUM_SRC*REG_W-1:0]  in_reg;
  logic [NUM_SRC-1:0]        in_imm_en;
  logic [NUM_SRC*DATA_W-1:0] in_imm;
  logic [CTRL_W-1:0]         in_ctrl;
  logic [NUM_SRC-1:0]        rf_read;
  logic [NUM_SRC*REG_W-1:0]  rf_reg;
  logic [NUM_SRC*DATA_W-1:0] rf_value;
  logic [NUM_FWD-1:0]        fwd_en;
  logic [NUM_FWD*REG_W-1:0]  fwd_dst;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic [NUM_FWD-1:0]        fwd_pending;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_SRC-1:0]        out_src_en;
  logic [NUM_SRC*DATA_W-1:0] out_src;
  logic [CTRL_W-1:0]         out_ctrl;
  logic [15:0]               stall_cnt;
  modport master (
    output in_valid, in_rd_en, in_reg, in_imm_en, in_imm, in_ctrl, rf_value,
           fwd_en, fwd_dst, fwd_data, fwd_pending, flush, out_ready,
    input  in_ready, rf_read, rf_reg, out_valid, out_src_en, out_src, out_ctrl, stall_cnt
  );
  modport slave (
    input  in_valid, in_rd_en, in_reg, in_imm_en, in_imm, in_ctrl, rf_value,
           fwd_en, fwd_dst, fwd_data, fwd_pending, flush, out_ready,
    output in_ready, rf_read, rf_reg, out_valid, out_src_en, out_src, out_ctrl, stall_cnt
  );
endinterface

// File: rtl/operand_read_stage.sv
// operand_read_stage: resolves operands (imm > youngest forward > regfile), stalls on pending forwards.
// Optional hazard stall counter enabled by OPERAND_READ_STALL_CNT_EN.
module operand_read_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 16,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int CTRL_W  = 16
) (
  input logic cpu_clk,
  input logic cpu_rst,
  operand_read_stage_if.slave bus
);
  localparam int REG_W = $clog2(REG_CNT);
  logic [NUM_SRC-1:0]        haz;
  logic [NUM_SRC*DATA_W-1:0] src;
  logic                      hazard;
  logic                      accept;
  assign bus.rf_read = {NUM_SRC{bus.in_valid}} & bus.in_rd_en & ~bus.in_imm_en;
  assign bus.rf_reg  = bus.in_reg;
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [DATA_W-1:0] v;
    logic              p;
    // scan oldest to youngest so the lowest matching slot wins
    always_comb begin
      v = bus.rf_value[s*DATA_W +: DATA_W];
      p = 1'b0;
      for (int j = NUM_FWD - 1; j >= 0; j--)
        if (bus.fwd_en[j] && bus.fwd_dst[j*REG_W +: REG_W] == bus.in_reg[s*REG_W +: REG_W]) begin
          v = bus.fwd_data[j*DATA_W +: DATA_W];
          p = bus.fwd_pending[j];
        end
    end
    assign haz[s] = bus.rf_read[s] & p;
    assign src[s*DATA_W +: DATA_W] = ~bus.in_rd_en[s] ? '0 :
                                     bus.in_imm_en[s] ? bus.in_imm[s*DATA_W +: DATA_W] : v;
  end
  assign hazard       = |haz;
  assign bus.in_ready = ~hazard & (~bus.out_valid | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;
  always_ff @(posedge cpu_clk or posedge cpu_rst)
    if (cpu_rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_src    <= '0;
      bus.out_src_en <= '0;
      bus.out_ctrl   <= '0;
    end else if (accept) begin
      bus.out_valid  <= 1'b1;
      bus.out_src    <= src;
      bus.out_src_en <= bus.in_rd_en;
      bus.out_ctrl   <= bus.in_ctrl;
    end else if (bus.flush || bus.out_ready) begin
      bus.out_valid  <= 1'b0;
    end
`ifdef OPERAND_READ_STALL_CNT_EN
  always_ff @(posedge cpu_clk or posedge cpu_rst)
    if (cpu_rst)
      bus.stall_cnt <= '0;
    else if (bus.in_valid && hazard && !bus.flush && !(&bus.stall_cnt))
      bus.stall_cnt <= bus.stall_cnt + 16'd1;
`else
  assign bus.stall_cnt = '0;
`endif
endmodule

// File: doc/operand_read_stage.md
# operand_read_stage

Parametrised operand-read pipeline stage between decode and execute. Resolves up to NUM_SRC source operands per instruction from the register file, from NUM_FWD prioritised forwarding sources, or from an immediate. Detects load-use style hazards and stalls upstream. Holds the result in a one-entry valid/ready output register, and carries an opaque control bundle alongside the operands.

## Interface
Parameters:
- DATA_W, 16, operand width
- REG_CNT, 16, architectural register count; REG_W = $clog2(REG_CNT)
- NUM_SRC, 2, source operands per instruction
- NUM_FWD, 2, forwarding sources; index 0 = youngest, highest priority
- CTRL_W, 16, width of pass-through control bundle

Ports:
- cpu_clk  in  1  clock
- cpu_rst  in  1  reset. Reset is asynchronous and active-high.
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_rd_en  in  NUM_SRC  per-source enable
- in_reg  in  NUM_SRC*REG_W  per-source register index
- in_imm_en  in  NUM_SRC  per-source immediate select, overrides register
- in_imm  in  NUM_SRC*DATA_W  per-source immediate, already extended
- in_ctrl  in  CTRL_W  control bundle
- rf_read  out  NUM_SRC  register file read strobe
- rf_reg  out  NUM_SRC*REG_W  register file index
- rf_value  in  NUM_SRC*DATA_W  register file data, same-cycle combinational
- fwd_en  in  NUM_FWD  forwarding slot holds a register-writing instruction
- fwd_dst  in  NUM_FWD*REG_W  slot destination register
- fwd_data  in  NUM_FWD*DATA_W  slot result
- fwd_pending  in  NUM_FWD  slot result not yet available
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  operands valid
- out_ready  in  1  execute accepts
- out_src_en  out  NUM_SRC  per-source enable, registered
- out_src  out  NUM_SRC*DATA_W  resolved operands
- out_ctrl  out  CTRL_W  registered control bundle
- stall_cnt  out  16  hazard stall cycle counter

## Operation
- rf_read[i] = in_valid & in_rd_en[i] & ~in_imm_en[i]; rf_reg = in_reg, unconditionally.
- Per source i, value selection:
  - if in_imm_en[i], use in_imm[i].
  - else the lowest-index slot j with fwd_en[j] and fwd_dst[j]==in_reg[i] supplies fwd_data[j].
  - else use rf_value[i].
  - Lower-priority matching slots are ignored.
- Hazard: in_valid, and some source i with rd_en, ~imm_en, whose winning (highest-priority) matching slot has fwd_pending set. A pending slot shadowed by a higher-priority non-pending match is not a hazard.
- in_ready = ~hazard & (~out_valid | out_ready). Accept = in_valid & in_ready & ~flush.
- On accept: the output register loads out_src, out_src_en = in_rd_en, and out_ctrl; out_valid is set.
- If out_valid & out_ready and no accept, out_valid clears.
- Disabled sources drive 0 on out_src.
- flush: out_valid clears next edge; an input offered in the same cycle is dropped. in_ready still reflects the formula.
- stall_cnt increments each cycle in_valid & hazard & ~flush, saturating at 16'hFFFF.
- Reset values: out_valid=0, out_src=0, out_src_en=0, out_ctrl=0, stall_cnt=0. Combinational outputs follow their inputs during reset. Reset mid-stall drops the held instruction.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Full throughput (1 instruction/cycle) when out_ready is held high and there is no hazard.
- Back-pressure: while out_valid & ~out_ready, the output holds stable and in_ready=0.
- A hazard resolves the same cycle fwd_pending drops. The instruction is accepted that edge with the forwarded data.
- Forwarding and register file inputs are sampled only at the accept edge; there is no internal retry state.

## Configuration
- OPERAND_READ_STALL_CNT_EN
  - Defined: the stall_cnt register exists, with the behaviour above.
  - Undefined: stall_cnt is tied to 0 and no counter flops are generated.

## Test plan
- No hazard, out_ready=1: in_reg={3,5}, rf_value={0x1111,0x2222} → next cycle out_valid=1, out_src={0x1111,0x2222}; back-to-back instructions give one output per cycle.
- Forward priority: src0 reg 4, fwd_en=2'b11, fwd_dst={4,4}, fwd_data[0]=0xAAAA, fwd_data[1]=0xBBBB → out_src[0]=0xAAAA.
- Immediate override: in_imm_en[1]=1, in_imm[1]=0x00FF, slot 0 matching in_reg[1] → out_src[1]=0x00FF; rf_read[1]=0.
- Load-use: slot 0 dst=7, pending for 3 cycles, src0 reg 7 → in_ready=0 for 3 cycles; accepted on the 4th with fwd_data[0]; stall_cnt=3 with macro defined, 0 without.
- Back-pressure then flush: out_ready=0 for 2 cycles → out_src stable and in_ready=0; flush → out_valid=0 next cycle, and the input offered that cycle never appears.
- Asynchronous reset asserted mid-cycle while out_valid=1 → out_valid=0 immediately, without waiting for a clock edge.
